ahbl_slv_mem: RTL
=================

Name: ahbl_slv_mem

Overview:
AHB-Lite slave (responder) holding a word-organised register-based memory. It is the completer-side counterpart of the AHB-Lite master interface, and it sits on the bus fabric as a bench and system target. It has programmable wait states and byte/halfword/word access, and it returns a two-cycle ERROR response for out-of-range or misaligned transfers.

Parameters:
AHBL_ADDR_WIDTH, 32, haddr width.
AHBL_DATA_WIDTH, 32, hwdata/hrdata width; fixed at 32 in this revision.
MEM_DEPTH, 256, number of 32-bit words; power of 2, at least 2.
WAIT_CYCLES, 0, wait states inserted in every OKAY data phase, range 0..15.

Ports:
hclk  in  1  bus clock; all logic is on the rising edge.
hreset  in  1  synchronous, active-high reset.
hsel  in  1  slave select.
haddr  in  AHBL_ADDR_WIDTH  address.
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
hwrite  in  1  1 = write.
hsize  in  3  000 byte, 001 half, 010 word; others are illegal.
hburst  in  3  accepted and ignored; every beat is decoded independently.
hprot  in  4  ignored.
hmastlock  in  1  ignored.
hready  in  1  bus-level ready; qualifies the address phase.
hwdata  in  AHBL_DATA_WIDTH  write data, sampled in the data phase.
hreadyout  out  1  slave ready.
hresp  out  2  00 OKAY, 01 ERROR.
hrdata  out  AHBL_DATA_WIDTH  read data.

Behaviour:
- Reset (hreset=1 at a hclk edge):
  - state=IDLE, hreadyout=1, hresp=00, hrdata=0, wait counter=0.
  - Pending transfer is discarded. Memory contents are preserved (not cleared).
  - Reset mid data phase: the pending write is dropped. The first cycle after reset is IDLE.
- Address-phase accept: hsel & hready & htrans[1] at a rising edge. On accept, latch haddr, hwrite, hsize.
- Transfers that are not accepted produce no state change:
  - IDLE or BUSY, when selected, get a zero-wait OKAY.
  - hsel=0 is ignored.
- Error check at accept, in this priority:
  - hsize > 010.
  - Misaligned: half with haddr[0]=1; word with haddr[1:0]!=0.
  - Word index haddr[AW-1:2] >= MEM_DEPTH.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=00. On accept:
    - error -> ERR1.
    - else WAIT_CYCLES>0 -> WAIT, counter loaded with WAIT_CYCLES-1.
    - else the data phase completes in the next cycle (stay IDLE-pipelined; see below).
  - WAIT: hreadyout=0, hresp=00. Counter decrements each cycle. At 0, the next cycle is the completing cycle (hreadyout=1).
  - ERR1: hreadyout=0, hresp=01, unconditional -> ERR2.
  - ERR2: hreadyout=1, hresp=01. Accepts a new address phase in the same cycle, like IDLE.
- Completing cycle: the data-phase cycle with hreadyout=1.
  - Reads: hrdata = lane-positioned memory word at the latched address, combinationally from the array. All 32 bits of the addressed word are driven, so the master selects its lanes.
  - When not in a read completing cycle, hrdata=0.
  - Writes: at the end of the completing cycle, update only the byte lanes selected by the latched size and addr[1:0] from hwdata. Little-endian: a byte at addr[1:0]=k uses hwdata[8k+7:8k].
- Pipelining:
  - With WAIT_CYCLES=0, back-to-back NONSEQ/SEQ beats complete one per cycle.
  - The address phase of beat N+1 overlaps the data phase of beat N.
  - A new accept is only possible when hready=1, i.e. on completing cycles.
- Read-after-write to the same address in consecutive beats returns the newly written data (the write commits before the read's data phase).
- An ERROR does not modify memory.

Test Plan:
- Reset: assert hreset for 2 cycles mid-WAIT -> hreadyout=1, hresp=00, hrdata=0 the next cycle; the interrupted write is not applied.
- WAIT_CYCLES=0: word write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> read completing cycle hrdata=0xDEADBEEF, hresp=00, no hreadyout low cycle.
- Byte lanes: word write 0x00000000 to 0x20; byte write 0xAA to 0x21 (hwdata=0x0000AA00); half write 0x1234 to 0x22 (hwdata=0x12340000); word read 0x20 -> 0x1234AA00.
- WAIT_CYCLES=3: single read -> hreadyout low for exactly 3 cycles, then 1 with valid hrdata.
- Errors:
  - Word read at 0x00000002 -> ERR1 (hreadyout=0, hresp=01), then ERR2 (hreadyout=1, hresp=01).
  - Same for address 4*MEM_DEPTH (0x400 at default depth).
  - Memory unchanged after an erroring write.
- BUSY/IDLE/hsel=0 interleaved in a 4-beat INCR burst at 0x40..0x4C -> BUSY gets a zero-wait OKAY; all 4 words are written and read back correctly.

Source files
------------

// File: rtl/ahbl_slv_mem.sv
// ahbl_slv_mem
// AHB-Lite slave backed by a word-organised register memory. Supports byte,
// halfword and word accesses, a fixed number of wait states on every OKAY
// data phase, and a two-cycle ERROR response for illegal sizes, misaligned
// addresses and addresses beyond the end of the array.
//
// Ports:
//   hclk, hreset          clock and synchronous active-high reset
//   hsel, haddr, htrans   address-phase select, address and transfer type
//   hwrite, hsize         direction and access size (byte/half/word)
//   hburst, hprot,
//   hmastlock             accepted but unused; every beat is decoded alone
//   hready                bus-level ready, qualifies the address phase
//   hwdata                write data, sampled in the data phase
//   hreadyout, hresp      slave ready and response (00 OKAY, 01 ERROR)
//   hrdata                read data, zero outside a read completing cycle
module ahbl_slv_mem #(
  parameter int AHBL_ADDR_WIDTH = 32,
  parameter int AHBL_DATA_WIDTH = 32,
  parameter int MEM_DEPTH       = 256,
  parameter int WAIT_CYCLES     = 0
) (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic                       hsel,
  input  logic [AHBL_ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]                 htrans,
  input  logic                       hwrite,
  input  logic [2:0]                 hsize,
  input  logic [2:0]                 hburst,
  input  logic [3:0]                 hprot,
  input  logic                       hmastlock,
  input  logic                       hready,
  input  logic [AHBL_DATA_WIDTH-1:0] hwdata,
  output logic                       hreadyout,
  output logic [1:0]                 hresp,
  output logic [AHBL_DATA_WIDTH-1:0] hrdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state, state_next;
  logic [3:0] wait_cnt, cnt_next;

  // Latched address-phase information for the transfer currently in its
  // data phase. Only the in-range address bits are kept.
  logic             data_valid;
  logic [IDX_W+1:0] addr_q;
  logic             write_q;
  logic [1:0]       size_q;

  logic can_accept, accept;
  logic size_err, align_err, range_err, xfer_err;
  logic completing;
  logic [3:0] byte_en;
  logic [IDX_W-1:0] word_idx;

  logic [AHBL_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Sideband inputs carry no meaning for this slave.
  logic unused_inputs;
  assign unused_inputs = ^{hburst, hprot, hmastlock, htrans[0]};

  // A new address phase can only be taken while this slave is showing
  // hreadyout=1 (IDLE or the second ERROR cycle).
  assign can_accept = (state == ST_IDLE) || (state == ST_ERR2);
  assign accept     = can_accept & hsel & hready & htrans[1];

  // All error causes lead to the same response, so their relative priority
  // does not change any observable behaviour.
  assign size_err  = (hsize > 3'b010);
  assign align_err = ((hsize == 3'b001) & haddr[0]) |
                     ((hsize == 3'b010) & (haddr[1:0] != 2'b00));
  assign range_err = |haddr[AHBL_ADDR_WIDTH-1:IDX_W+2];
  assign xfer_err  = size_err | align_err | range_err;

  // The data phase completes in the first IDLE cycle after the accept,
  // whether it arrived there directly or through the WAIT state.
  assign completing = data_valid && (state == ST_IDLE);
  assign word_idx   = addr_q[IDX_W+1:2];

  // Byte lanes touched by the latched access, little-endian.
  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      2'b00:   byte_en = 4'b0001 << addr_q[1:0];
      2'b01:   byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Next-state and bus response decode.
  always_comb begin
    state_next = state;
    cnt_next   = wait_cnt;
    hreadyout  = 1'b1;
    hresp      = 2'b00;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (state == ST_ERR2) hresp = 2'b01;
        state_next = ST_IDLE;
        if (accept) begin
          if (xfer_err) begin
            state_next = ST_ERR1;
          end else if (WAIT_CYCLES > 0) begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (wait_cnt == 4'd0) state_next = ST_IDLE;
        else                  cnt_next   = wait_cnt - 4'd1;
      end
      ST_ERR1: begin
        hreadyout  = 1'b0;
        hresp      = 2'b01;
        state_next = ST_ERR2;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and address-phase latch. An erroring accept clears
  // data_valid so nothing downstream treats it as a real transfer.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state      <= ST_IDLE;
      wait_cnt   <= 4'd0;
      data_valid <= 1'b0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
      if (can_accept) begin
        data_valid <= accept & ~xfer_err;
        if (accept) begin
          addr_q  <= haddr[IDX_W+1:0];
          write_q <= hwrite;
          size_q  <= hsize[1:0];
        end
      end
    end
  end

  // Memory array keeps its contents across reset; a write still pending
  // when reset arrives is simply dropped.
  always_ff @(posedge hclk) begin
    if (!hreset && completing && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  // Whole addressed word is returned; the master picks its own lanes.
  assign hrdata = (completing && !write_q) ? mem[word_idx] : '0;

endmodule
